// File: rtl/bit_count_ctrl_if.sv
// Request/response bundle for the bit-count controller.
// The master drives the op request and flush; the slave returns status and result.
interface bit_count_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, op, operand, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, operand, flush,
        output busy, done, result
    );
endinterface

// File: rtl/bit_count_ctrl.sv
// Bit-serial population count and leading/trailing zero/one counter.
// One bit of the scan register is examined per RUN cycle; the result is published on entry to DONE.
module bit_count_ctrl #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    bit_count_ctrl_if.slave  bus
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;
    localparam int unsigned SW = 5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_POP = 3'd0;
    localparam logic [2:0] OP_CLZ = 3'd1;
    localparam logic [2:0] OP_CLO = 3'd2;
    localparam logic [2:0] OP_CTZ = 3'd3;
    localparam logic [2:0] OP_CTO = 3'd4;

    logic [1:0]    state_q, state_d;
    logic [2:0]    op_q;
    logic [W-1:0]  scan_q;
    logic [W-1:0]  operand_rev;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] res_q;
    logic [CW-1:0] res_d;
    logic [SW-1:0] step_q;
    logic          stop_q;
    logic          busy_q;
    logic          done_q;

    logic          load;
    logic          step_en;
    logic          res_load;
    logic          op_valid;
    logic          bit0;
    logic          match;
    logic          hit;
    logic          term;
    logic          last;

    // Leading-count ops scan the bit-reversed word so every op walks from bit 0 upward.
    always_comb begin
        operand_rev = '0;
        for (int unsigned i = 0; i < W; i++) begin
            operand_rev[i] = bus.operand[W-1-i];
        end
    end

    // Per-step evaluation of the examined bit.
    always_comb begin
        bit0     = scan_q[0];
        match    = ((op_q == OP_CLZ) || (op_q == OP_CTZ)) ? ~bit0 : bit0;
        hit      = (op_q == OP_POP) ? bit0 : (match & ~stop_q);
        term     = (op_q != OP_POP) & ~match & ~stop_q;
        cnt_inc  = cnt_q + CW'(hit);
        last     = (step_q == SW'(W - 1)) | (EARLY_EXIT && term);
        op_valid = (bus.op <= OP_CTO);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        step_en  = 1'b0;
        res_load = 1'b0;
        res_d    = cnt_inc;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    if (op_valid) begin
                        load    = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        res_load = 1'b1;
                        res_d    = '0;
                        state_d  = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // Flush wins over a step that would otherwise complete the op.
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    step_en = 1'b1;
                    if (last) begin
                        res_load = 1'b1;
                        state_d  = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == S_RUN);
            done_q  <= (state_d == S_DONE);
        end
    end

    // Scan register, counters and published result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q   <= OP_POP;
            scan_q <= '0;
            cnt_q  <= '0;
            step_q <= '0;
            stop_q <= 1'b0;
            res_q  <= '0;
        end else begin
            if (load) begin
                op_q   <= bus.op;
                scan_q <= ((bus.op == OP_CLZ) || (bus.op == OP_CLO)) ? operand_rev : bus.operand;
                cnt_q  <= '0;
                step_q <= '0;
                stop_q <= 1'b0;
            end else if (step_en) begin
                scan_q <= scan_q >> 1;
                cnt_q  <= cnt_inc;
                step_q <= step_q + SW'(1);
                stop_q <= stop_q | term;
            end
            if (res_load) begin
                res_q <= res_d;
            end
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = {{(W-CW){1'b0}}, res_q};

endmodule

// File: tb/tb_bit_count_ctrl.sv
// Scoreboard bench for bit_count_ctrl: one early-exit and one full-scan instance share stimulus.
// Expected result and RUN-cycle count come from a bit-walking model of the count rules.
module tb_bit_count_ctrl;

    typedef struct {
        int res;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    int   run_cnt[2];
    logic [31:0] prev_res[2];

    bit_count_ctrl_if ia();
    bit_count_ctrl_if ib();

    bit_count_ctrl #(.EARLY_EXIT(1'b1)) dut_a (.clk(clk), .reset(rst_n), .bus(ia));
    bit_count_ctrl #(.EARLY_EXIT(1'b0)) dut_b (.clk(clk), .reset(rst_n), .bus(ib));

    always #5 clk = ~clk;

    // Reference: walk the word in scan order and count per the op's rule.
    function automatic void model(input logic [2:0] o, input logic [31:0] v, input bit ee,
                                  output int res, output int cyc);
        logic want;
        int   pos;
        res = 0;
        cyc = 0;
        case (o)
            3'd0: begin
                res = $countones(v);
                cyc = 32;
            end
            3'd1, 3'd2, 3'd3, 3'd4: begin
                want = (o == 3'd2) || (o == 3'd4);
                for (int i = 0; i < 32; i++) begin
                    pos = (o == 3'd1 || o == 3'd2) ? 31 - i : i;
                    if (v[pos] != want) break;
                    res++;
                end
                cyc = (!ee || res == 32) ? 32 : res + 1;
            end
            default: begin
                res = 0;
                cyc = 0;
            end
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic s, input logic [2:0] o, input logic [31:0] v, input logic f);
        ia.start = s; ia.op = o; ia.operand = v; ia.flush = f;
        ib.start = s; ib.op = o; ib.operand = v; ib.flush = f;
    endtask

    // Present one start for a cycle; optionally register its expected outcome.
    task automatic issue(input logic [2:0] o, input logic [31:0] v, input logic f, input bit push);
        exp_t e;
        if (push) begin
            model(o, v, 1'b1, e.res, e.cyc);
            qa.push_back(e);
            model(o, v, 1'b0, e.res, e.cyc);
            qb.push_back(e);
        end
        drive(1'b1, o, v, f);
        @(posedge clk);
        #1 drive(1'b0, 3'($urandom), $urandom, 1'b0);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #2;
            if (qa.size() == 0 && qb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL timeout: %0d/%0d responses outstanding, expected 0", qa.size(), qb.size());
            qa.delete();
            qb.delete();
        end
        @(negedge clk);
    endtask

    task automatic mon(input int id, input logic busy, input logic done, input logic [31:0] result);
        exp_t e;
        bit   empty;
        checks++;
        if (busy && done) begin
            errors++;
            $display("FAIL busy_done_overlap[%0d]: busy=%0b done=%0b", id, busy, done);
        end
        if (done) begin
            empty = (id == 0) ? (qa.size() == 0) : (qb.size() == 0);
            checks++;
            if (empty) begin
                errors++;
                $display("FAIL unexpected_done[%0d]: result=%0d with no op outstanding", id, result);
            end else begin
                if (id == 0) e = qa.pop_front();
                else         e = qb.pop_front();
                if (result !== 32'(e.res)) begin
                    errors++;
                    $display("FAIL result[%0d]: got %0d, expected %0d", id, result, e.res);
                end
                checks++;
                if (run_cnt[id] != e.cyc) begin
                    errors++;
                    $display("FAIL run_cycles[%0d]: got %0d, expected %0d", id, run_cnt[id], e.cyc);
                end
            end
            run_cnt[id] = 0;
        end else begin
            checks++;
            if (result !== prev_res[id]) begin
                errors++;
                $display("FAIL result_hold[%0d]: got %0d, expected %0d", id, result, prev_res[id]);
            end
            if (busy) run_cnt[id]++;
            else      run_cnt[id] = 0;
        end
        prev_res[id] = result;
    endtask

    // Monitor: observe both instances away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                run_cnt[i] = 0;
            end
            prev_res[0] = ia.result;
            prev_res[1] = ib.result;
        end else begin
            mon(0, ia.busy, ia.done, ia.result);
            mon(1, ib.busy, ib.done, ib.result);
        end
    end

    initial begin
        logic [31:0] ra, rb, v;
        logic [2:0]  o;
        bit          got;

        rst_n = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset_busy_a", 32'(ia.busy), 32'd0);
        chk("reset_done_a", 32'(ia.done), 32'd0);
        chk("reset_result_a", ia.result, 32'd0);
        chk("reset_busy_b", 32'(ib.busy), 32'd0);
        chk("reset_result_b", ib.result, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        issue(3'd0, 32'hF0F0_0001, 1'b0, 1'b1); wait_idle();
        issue(3'd3, 32'h0000_0008, 1'b0, 1'b1); wait_idle();
        issue(3'd3, 32'h0000_0000, 1'b0, 1'b1); wait_idle();
        issue(3'd1, 32'h8000_0000, 1'b0, 1'b1); wait_idle();
        issue(3'd2, 32'hFFFF_FFFF, 1'b0, 1'b1); wait_idle();
        issue(3'd7, 32'h1234_5678, 1'b0, 1'b1); wait_idle();

        // Start during RUN is ignored; a start (with flush) in the DONE cycle is accepted.
        issue(3'd0, 32'h1234_5678, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        drive(1'b1, 3'd3, 32'd0, 1'b0);
        @(posedge clk);
        #1 drive(1'b0, 3'd0, 32'd0, 1'b0);
        got = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (ia.done) begin
                got = 1'b1;
                break;
            end
        end
        chk("b2b_done_seen", 32'(got), 32'd1);
        issue(3'd4, 32'h0000_0007, 1'b1, 1'b1);
        wait_idle();

        // Flush mid-POP: back to idle with no done and result untouched.
        ra = ia.result;
        rb = ib.result;
        issue(3'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        drive(1'b0, 3'd0, 32'd0, 1'b1);
        @(posedge clk);
        #1 drive(1'b0, 3'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("flush_busy_a", 32'(ia.busy), 32'd0);
        chk("flush_busy_b", 32'(ib.busy), 32'd0);
        chk("flush_result_a", ia.result, ra);
        chk("flush_result_b", ib.result, rb);
        repeat (3) @(negedge clk);

        // Reset mid-RUN clears state without waiting for a clock edge.
        issue(3'd3, 32'h0000_0000, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy_a", 32'(ia.busy), 32'd0);
        chk("rst_mid_busy_b", 32'(ib.busy), 32'd0);
        chk("rst_mid_result_a", ia.result, 32'd0);
        chk("rst_mid_result_b", ib.result, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        issue(3'd3, 32'h0000_0008, 1'b0, 1'b1); wait_idle();

        for (int t = 0; t < 40; t++) begin
            o = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: v = $urandom;
                1: v = $urandom >> $urandom_range(0, 31);
                2: v = $urandom << $urandom_range(0, 31);
                3: v = ~($urandom >> $urandom_range(0, 31));
                default: v = ~($urandom << $urandom_range(0, 31));
            endcase
            issue(o, v, 1'($urandom_range(0, 1)), 1'b1);
            wait_idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
